// File: rtl/paralelo_serial_param_if.sv
// Word-in / bit-out bus for the parallel-to-serial transmit converter.
// The producer side drives the word handshake; the serial side returns the bit stream and its framing flags.
interface paralelo_serial_param_if #(
    parameter int unsigned WIDTH = 8
);

    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             data_out;
    logic             frame_out;
    logic             active_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  data_out,
        input  frame_out,
        input  active_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output data_out,
        output frame_out,
        output active_out
    );

endinterface

// File: rtl/paralelo_serial_param.sv
// Parallel-to-serial converter: valid/ready word intake into a small FIFO, one bit per clk_32f,
// with an idle symbol inserted whenever no word is queued at a word boundary.
module paralelo_serial_param #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] IDLE_SYM  = WIDTH'(8'hBC),
    parameter bit               MSB_FIRST = 1'b1
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    paralelo_serial_param_if.slave bus
);

    localparam int unsigned CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned COUNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(DEPTH);

    logic [CNT_W-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]   r_shreg;
    logic               r_act;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [COUNT_W-1:0] r_count;

    logic               w_ready;
    logic               w_push;
    logic               w_load;
    logic               w_pop;
    logic [WIDTH-1:0]   w_head;
    logic [WIDTH-1:0]   w_shift;
    logic [PTR_W-1:0]   w_rd_ptr_nxt;
    logic [PTR_W-1:0]   w_wr_ptr_nxt;
    logic [COUNT_W-1:0] w_count_nxt;

    // Handshake and load decisions all use FIFO state from before the edge (no bypass).
    assign w_ready = (r_count < FULL_CNT);
    assign w_push  = bus.valid_in && w_ready;
    assign w_load  = (r_bit_cnt == LAST_BIT);
    assign w_pop   = w_load && (r_count != '0);
    assign w_head  = r_mem[r_rd_ptr];

    // Shift one position toward the output end, zero fill behind.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_shift = {1'b0, r_shreg[WIDTH-1:1]};
        end
    endgenerate

    // Pointer and occupancy bookkeeping; wrap modulo DEPTH even when DEPTH is not a power of two.
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;

        if (w_pop) begin
            w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
        end
        if (w_push) begin
            w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
        end

        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + COUNT_W'(1);
            2'b01:   w_count_nxt = r_count - COUNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_32f) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    // Bit timing and the word being serialised.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_shreg   <= IDLE_SYM;
            r_act     <= 1'b0;
        end else begin
            r_bit_cnt <= w_load ? '0 : r_bit_cnt + CNT_W'(1);
            if (w_load) begin
                r_shreg <= w_pop ? w_head : IDLE_SYM;
                r_act   <= w_pop;
            end else begin
                r_shreg <= w_shift;
            end
        end
    end

    assign bus.ready_out  = w_ready;
    assign bus.data_out   = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign bus.frame_out  = (r_bit_cnt == '0);
    assign bus.active_out = r_act;

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Bench for paralelo_serial_param: an 8-bit MSB-first instance and a 10-bit LSB-first instance,
// compared every cycle against a word-queue reference model plus directed constant checks.
module tb_paralelo_serial_param;

    localparam int unsigned WA    = 8;
    localparam int unsigned WB    = 10;
    localparam int unsigned DEPTH = 2;
    localparam logic [15:0] IDLE_A = 16'h00BC;
    localparam logic [15:0] IDLE_B = 16'h017C;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    paralelo_serial_param_if #(.WIDTH(WA)) bus_a ();
    paralelo_serial_param_if #(.WIDTH(WB)) bus_b ();

    paralelo_serial_param #(
        .WIDTH(WA), .DEPTH(DEPTH), .IDLE_SYM(8'hBC), .MSB_FIRST(1'b1)
    ) dut_a (
        .clk_32f(clk), .reset(rst), .bus(bus_a)
    );

    paralelo_serial_param #(
        .WIDTH(WB), .DEPTH(DEPTH), .IDLE_SYM(10'h17C), .MSB_FIRST(1'b0)
    ) dut_b (
        .clk_32f(clk), .reset(rst), .bus(bus_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: position within the current word, the whole word being sent, its source, and the queue.
    int          ph_a, ph_b;
    logic [15:0] wd_a, wd_b;
    bit          act_a, act_b;
    logic [15:0] q_a [$];
    logic [15:0] q_b [$];

    function automatic logic exp_bit(input logic [15:0] w, input int width, input bit msb, input int ph);
        int idx;
        idx = msb ? (width - 1 - ph) : ph;
        return w[idx];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph_a = 0; wd_a = IDLE_A; act_a = 1'b0; q_a.delete();
        ph_b = 0; wd_b = IDLE_B; act_b = 1'b0; q_b.delete();
    endtask

    task automatic model_edge(input bit va, input logic [7:0] da, input bit vb, input logic [9:0] db);
        bit pa, pb;
        if (rst) begin
            model_reset();
            return;
        end
        pa = va && (q_a.size() < int'(DEPTH));
        pb = vb && (q_b.size() < int'(DEPTH));
        if (ph_a == int'(WA) - 1) begin
            if (q_a.size() > 0) begin wd_a = q_a.pop_front(); act_a = 1'b1; end
            else                begin wd_a = IDLE_A;          act_a = 1'b0; end
        end
        if (ph_b == int'(WB) - 1) begin
            if (q_b.size() > 0) begin wd_b = q_b.pop_front(); act_b = 1'b1; end
            else                begin wd_b = IDLE_B;          act_b = 1'b0; end
        end
        if (pa) q_a.push_back({8'h00, da});
        if (pb) q_b.push_back({6'h00, db});
        ph_a = (ph_a + 1) % int'(WA);
        ph_b = (ph_b + 1) % int'(WB);
    endtask

    task automatic check_all();
        check("a_data",   16'(bus_a.data_out),   16'(exp_bit(wd_a, WA, 1'b1, ph_a)));
        check("a_frame",  16'(bus_a.frame_out),  16'(ph_a == 0));
        check("a_active", 16'(bus_a.active_out), 16'(act_a));
        check("a_ready",  16'(bus_a.ready_out),  16'(q_a.size() < int'(DEPTH)));
        check("b_data",   16'(bus_b.data_out),   16'(exp_bit(wd_b, WB, 1'b0, ph_b)));
        check("b_frame",  16'(bus_b.frame_out),  16'(ph_b == 0));
        check("b_active", 16'(bus_b.active_out), 16'(act_b));
        check("b_ready",  16'(bus_b.ready_out),  16'(q_b.size() < int'(DEPTH)));
    endtask

    // One clock: drive inputs, advance model at the rising edge, compare at the falling edge.
    task automatic cycle(input bit va, input logic [7:0] da, input bit vb, input logic [9:0] db);
        bus_a.valid_in = va; bus_a.data_in = da;
        bus_b.valid_in = vb; bus_b.data_in = db;
        @(posedge clk);
        model_edge(va, da, vb, db);
        @(negedge clk);
        bus_a.valid_in = 1'b0;
        bus_b.valid_in = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 10'h000);
    endtask

    initial begin
        logic [7:0] pat_a;
        logic [9:0] pat_b;
        logic [7:0] w_a5;
        logic [9:0] w_283;
        bit         seen;

        pat_a = 8'hBC;
        pat_b = 10'h17C;
        w_a5  = 8'hA5;
        w_283 = 10'h283;

        rst = 1'b1;
        bus_a.valid_in = 1'b0; bus_a.data_in = '0;
        bus_b.valid_in = 1'b0; bus_b.data_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;
        check_all();

        // Idle streams straight after reset release.
        for (int i = 0; i < 10; i++) begin
            if (i < 8) check("idle_a_const", 16'(bus_a.data_out), 16'(pat_a[7 - i]));
            check("idle_b_const", 16'(bus_b.data_out), 16'(pat_b[i]));
            check("idle_a_inactive", 16'(bus_a.active_out), 16'd0);
            cycle(1'b0, 8'h00, 1'b0, 10'h000);
        end

        // Single push of A5 at bit position 3: four further edges to load, then eight data bits.
        for (int i = 0; i < 16 && ph_a != 3; i++) idle(1);
        cycle(1'b1, w_a5, 1'b0, 10'h000);
        idle(4);
        for (int i = 0; i < 8; i++) begin
            check("a5_bit",    16'(bus_a.data_out),   16'(w_a5[7 - i]));
            check("a5_active", 16'(bus_a.active_out), 16'd1);
            check("a5_frame",  16'(bus_a.frame_out),  16'(i == 0));
            idle(1);
        end
        check("a5_back_to_idle", 16'(bus_a.active_out), 16'd0);

        // LSB-first 10-bit word.
        cycle(1'b0, 8'h00, 1'b1, w_283);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus_b.active_out === 1'b1) begin seen = 1'b1; break; end
            idle(1);
        end
        check("b283_arrived", 16'(seen), 16'd1);
        for (int i = 0; i < 10; i++) begin
            check("b283_bit", 16'(bus_b.data_out), 16'(w_283[i]));
            idle(1);
        end

        // Burst of three at a word start: the third meets a full FIFO and is dropped.
        idle(8);
        for (int i = 0; i < 16 && ph_a != 0; i++) idle(1);
        cycle(1'b1, 8'h01, 1'b0, 10'h000);
        cycle(1'b1, 8'h02, 1'b0, 10'h000);
        check("burst_full", 16'(bus_a.ready_out), 16'd0);
        cycle(1'b1, 8'h03, 1'b0, 10'h000);
        idle(32);

        // Push coinciding with a pop at the load edge while one word is queued.
        for (int i = 0; i < 16 && ph_a != 0; i++) idle(1);
        cycle(1'b1, 8'h5A, 1'b0, 10'h000);
        for (int i = 0; i < 16 && ph_a != int'(WA) - 1; i++) idle(1);
        cycle(1'b1, 8'hC3, 1'b0, 10'h000);
        check("pushpop_ready",  16'(bus_a.ready_out),  16'd1);
        check("pushpop_active", 16'(bus_a.active_out), 16'd1);
        check("pushpop_first",  16'(bus_a.data_out),   16'd0);
        idle(8);
        check("pushpop_next_active", 16'(bus_a.active_out), 16'd1);
        check("pushpop_next_first",  16'(bus_a.data_out),   16'd1);
        idle(16);

        // Reset in the middle of a word with two words queued.
        for (int i = 0; i < 16 && ph_a != 0; i++) idle(1);
        cycle(1'b1, 8'h11, 1'b1, 10'h0AA);
        cycle(1'b1, 8'h22, 1'b1, 10'h155);
        idle(1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_a_data",   16'(bus_a.data_out),   16'd1);
        check("rst_a_frame",  16'(bus_a.frame_out),  16'd1);
        check("rst_a_active", 16'(bus_a.active_out), 16'd0);
        check("rst_a_ready",  16'(bus_a.ready_out),  16'd1);
        check("rst_b_data",   16'(bus_b.data_out),   16'd0);
        check("rst_b_frame",  16'(bus_b.frame_out),  16'd1);
        @(negedge clk);
        check_all();
        rst = 1'b0;
        check_all();
        for (int i = 0; i < 24; i++) begin
            if (i < 8) check("post_rst_idle", 16'(bus_a.data_out), 16'(pat_a[7 - i]));
            check("post_rst_a_inactive", 16'(bus_a.active_out), 16'd0);
            check("post_rst_b_inactive", 16'(bus_b.active_out), 16'd0);
            idle(1);
        end

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 5) == 0), 8'($urandom), ($urandom_range(0, 6) == 0), 10'($urandom));
        end
        idle(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/paralelo_serial_param.md
# paralelo_serial_param

Parametrised parallel-to-serial converter for the physical layer transmit path. It accepts WIDTH-bit words through a valid/ready handshake into a DEPTH-entry holding FIFO and serialises one bit per clk_32f cycle. When no word is queued it inserts an idle symbol, 8'hBC by default. It also provides word-boundary and data/idle indicators for downstream framing and monitors.

## Interface

- WIDTH, 8: bits per word; must be at least 2.
- DEPTH, 2: holding FIFO entries; must be at least 1.
- IDLE_SYM, 8'hBC (WIDTH bits): word transmitted when the FIFO is empty at a load point.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- clk_32f  input  1  bit-rate clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  parallel word.
- valid_in  input  1  data_in is valid this cycle.
- ready_out  output  1  FIFO can accept a word.
- data_out  output  1  serial bit.
- frame_out  output  1  high during the cycle data_out carries the first bit of a word.
- active_out  output  1  high while the word being shifted came from the FIFO; low for idle.

## Operation

- Internal state:
  - bit_cnt: 0..WIDTH-1.
  - shreg: WIDTH-bit shift register.
  - FIFO: DEPTH entries, with rd_ptr, wr_ptr and count (0..DEPTH).
  - act_q: source flag for the word in shreg.
- Reset (asynchronous, held while reset=1):
  - bit_cnt=0, shreg=IDLE_SYM, FIFO empty (pointers and count = 0), act_q=0.
  - Output values during reset: ready_out=1 (count<DEPTH); frame_out=1; active_out=0.
  - data_out = IDLE_SYM[WIDTH-1] if MSB_FIRST=1, otherwise IDLE_SYM[0]. For the defaults this is 1.
- Push: a word is written when valid_in=1 and ready_out=1 at a rising edge.
  - ready_out = (count < DEPTH). It depends only on count, never on valid_in or on a pop in the same cycle.
  - valid_in while full is ignored; the word is dropped and nothing changes.
- Bit counter: increments each edge; wraps from WIDTH-1 to 0.
- Load point: the edge where bit_cnt == WIDTH-1.
  - If count>0 (value before the edge): shreg <= FIFO head, pop, act_q <= 1.
  - Otherwise: shreg <= IDLE_SYM, act_q <= 0.
- Other edges: shreg shifts by one toward the output end.
  - MSB_FIRST=1: shift left, zero fill.
  - MSB_FIRST=0: shift right, zero fill.
- Output mapping (combinational from registers):
  - data_out = shreg[WIDTH-1] if MSB_FIRST=1, otherwise shreg[0].
  - frame_out = (bit_cnt == 0).
  - active_out = act_q.
- Push and pop at the same edge: both take effect; count is unchanged and pointers advance modulo DEPTH.
- No bypass path: the load decision uses FIFO state before the edge. A word pushed at a load edge waits for the next load point.
- Reset mid-word: the partial word is abandoned and all FIFO contents are discarded. The first word after reset is a full IDLE_SYM.

## Timing

- Throughput: one word per WIDTH cycles. Sustained input at that rate never fills the FIFO.
- Push-to-first-bit latency, with an empty FIFO and the push at an edge where bit_cnt=k before the edge:
  - The word loads after (WIDTH-1-k) further edges when k<WIDTH-1, or WIDTH further edges when k=WIDTH-1.
  - Its first bit is on data_out in the cycle immediately after the load edge, with frame_out=1 and active_out=1.
- Idle symbol: one full IDLE_SYM word is emitted whenever the FIFO is empty at a load point. Words are never partial.
- ready_out falls in the cycle after the push that makes count==DEPTH. It rises in the cycle after the pop that leaves count<DEPTH.

## Test plan

1. Reset release, no valid_in, defaults: data_out repeats 1,0,1,1,1,1,0,0 (8'hBC MSB-first). frame_out is high every 8th cycle, aligned to the first 1. active_out=0 throughout.
2. Single push of 8'hA5 at bit_cnt=3, defaults: the word loads 4 edges later. Next 8 bits are 1,0,1,0,0,1,0,1 with active_out=1, then idle 8'hBC resumes with active_out=0.
3. Burst: push 8'h01, 8'h02, 8'h03 on consecutive cycles with DEPTH=2.
   - Third push is accepted only if a pop has occurred; otherwise ready_out=0 and it is dropped.
   - Bench checks the emitted sequence against the accepted words, gap-free at 8 cycles per word.
4. MSB_FIRST=0, WIDTH=10, IDLE_SYM=10'h17C:
   - Idle stream is 0,0,1,1,1,1,1,0,1,0 (LSB first).
   - Pushed 10'h283 emits 1,1,0,0,0,0,0,1,0,1.
5. Simultaneous push and pop at a load edge with count=1: count stays 1, the popped word is emitted, and the new word follows it back-to-back.
6. Reset asserted mid-word with 2 words queued:
   - All outputs return immediately to their reset values.
   - After release, a full 8'hBC word is emitted with active_out=0; the queued words are never sent.
